// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: latch/PC enables, bubble strobes, halt.
// Optional performance counters are built only when PIPE_CTRL_PERF_EN is defined.
module pipeline_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             mem_req_ex,
  input  logic             load_use,
  input  logic             branch_taken,
  input  logic             jump,
  input  logic             halt_mem,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             dmem_req_mask,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;

  state_t state_reg, state_next;
  logic   dmem_done_reg, dmem_done_next;
  logic   lu_done_reg, lu_done_next;
  logic   stall_inc, flush_inc;
  logic   dmem_busy, advance;

  // A completed data access no longer holds the pipe even if EX/MEM still requests it.
  assign dmem_busy = mem_req_ex & ~dhit & ~dmem_done_reg;
  assign advance   = ihit & ~dmem_busy;

  always_comb begin
    state_next     = state_reg;
    dmem_done_next = dmem_done_reg;
    lu_done_next   = lu_done_reg;
    stall_inc      = 1'b0;
    flush_inc      = 1'b0;
    pc_en          = 1'b0;
    ifid_en        = 1'b0;
    idex_en        = 1'b0;
    exmem_en       = 1'b0;
    memwb_en       = 1'b0;
    ifid_flush     = 1'b0;
    idex_flush     = 1'b0;
    exmem_flush    = 1'b0;
    dmem_req_mask  = 1'b0;
    halted         = 1'b0;

    // Outputs are Mealy, so they must be forced low while reset is held.
    if (nRST) begin
      dmem_req_mask = dmem_done_reg;
      if (state_reg == HALT) begin
        halted = 1'b1;
      end else if (halt_mem) begin
        memwb_en   = 1'b1;
        state_next = HALT;
      end else if (!advance) begin
        stall_inc = 1'b1;
        if (mem_req_ex && dhit && !ihit) dmem_done_next = 1'b1;
      end else if (branch_taken) begin
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        idex_en     = 1'b1;
        exmem_en    = 1'b1;
        memwb_en    = 1'b1;
        ifid_flush  = 1'b1;
        idex_flush  = 1'b1;
        exmem_flush = 1'b1;
        flush_inc   = 1'b1;
      end else if (load_use && !lu_done_reg) begin
        idex_en      = 1'b1;
        idex_flush   = 1'b1;
        exmem_en     = 1'b1;
        memwb_en     = 1'b1;
        lu_done_next = 1'b1;
      end else begin
        pc_en      = 1'b1;
        ifid_en    = 1'b1;
        idex_en    = 1'b1;
        exmem_en   = 1'b1;
        memwb_en   = 1'b1;
        ifid_flush = jump;
      end

      // Sticky flags retire once the instruction they protect moves on.
      if (ifid_en)  lu_done_next   = 1'b0;
      if (exmem_en) dmem_done_next = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_reg     <= RUN;
      dmem_done_reg <= 1'b0;
      lu_done_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      dmem_done_reg <= dmem_done_next;
      lu_done_reg   <= lu_done_next;
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  logic [CNT_W-1:0] stall_cnt_reg, flush_cnt_reg;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Both counters saturate at all-ones instead of wrapping.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stall_cnt_reg <= '0;
      flush_cnt_reg <= '0;
    end else begin
      if (stall_inc && !(&stall_cnt_reg)) stall_cnt_reg <= stall_cnt_reg + CNT_ONE;
      if (flush_inc && !(&flush_cnt_reg)) flush_cnt_reg <= flush_cnt_reg + CNT_ONE;
    end
  end

  assign stall_cnt = stall_cnt_reg;
  assign flush_cnt = flush_cnt_reg;
`else
  logic unused_perf;
  assign unused_perf = stall_inc ^ flush_inc;
  assign stall_cnt   = '0;
  assign flush_cnt   = '0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: directed vector table, reset cases, then random stimulus
// checked against a rule-level model of the stall/flush sequencer.
module tb_pipeline_ctrl;
  localparam int CNT_W = 32;
`ifdef PIPE_CTRL_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic CLK = 1'b0;
  logic nRST = 1'b1;
  logic ihit = 0, dhit = 0, mem_req_ex = 0, load_use = 0, branch_taken = 0, jump = 0, halt_mem = 0;
  logic pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic ifid_flush, idex_flush, exmem_flush, dmem_req_mask, halted;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  pipeline_ctrl #(.CNT_W(CNT_W)) dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .mem_req_ex(mem_req_ex),
    .load_use(load_use), .branch_taken(branch_taken), .jump(jump), .halt_mem(halt_mem),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
    .memwb_en(memwb_en), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .exmem_flush(exmem_flush), .dmem_req_mask(dmem_req_mask), .halted(halted),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 CLK = ~CLK;

  // Input vector {ihit,dhit,mem_req_ex,load_use,branch_taken,jump,halt_mem};
  // output vector {pc,ifid,idex,exmem,memwb en, ifid,idex,exmem flush, mask, halted}.
  typedef struct packed {
    logic [6:0] in;
    logic [9:0] out;
  } vec_t;

  vec_t tbl [19];
  int n_cmp = 0;
  int n_fail = 0;

  bit          m_halted, m_dmem_done, m_lu_done;
  logic [31:0] m_stall, m_flush;

  function automatic logic [9:0] dut_out();
    return {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
            ifid_flush, idex_flush, exmem_flush, dmem_req_mask, halted};
  endfunction

  function automatic bit m_advance(input logic [6:0] v);
    bit waiting;
    waiting = v[4] && !v[5] && !m_dmem_done;
    return v[6] && !waiting;
  endfunction

  function automatic logic [9:0] model_out(input logic [6:0] v);
    logic [7:0] strobes;
    if (m_halted) return {8'b0, m_dmem_done, 1'b1};
    if (v[0])                         strobes = 8'b00001_000;
    else if (!m_advance(v))           strobes = 8'b00000_000;
    else if (v[2])                    strobes = 8'b11111_111;
    else if (v[3] && !m_lu_done)      strobes = 8'b00111_010;
    else if (v[1])                    strobes = 8'b11111_100;
    else                              strobes = 8'b11111_000;
    return {strobes, m_dmem_done, 1'b0};
  endfunction

  function automatic void model_update(input logic [6:0] v);
    if (m_halted) return;
    if (v[0]) begin
      m_halted = 1'b1;
      return;
    end
    if (!m_advance(v)) begin
      if (m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
      if (v[4] && v[5] && !v[6]) m_dmem_done = 1'b1;
      return;
    end
    // Every advancing cycle moves EX/MEM; only the load-use bubble holds IF/ID.
    m_dmem_done = 1'b0;
    if (v[2]) begin
      if (m_flush != 32'hFFFF_FFFF) m_flush = m_flush + 1;
      m_lu_done = 1'b0;
    end else if (v[3] && !m_lu_done) begin
      m_lu_done = 1'b1;
    end else begin
      m_lu_done = 1'b0;
    end
  endfunction

  function automatic void model_reset();
    m_halted = 0; m_dmem_done = 0; m_lu_done = 0; m_stall = 0; m_flush = 0;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_cnts(input string tag);
    check({tag, " stall_cnt"}, stall_cnt, PERF ? m_stall : 32'd0);
    check({tag, " flush_cnt"}, flush_cnt, PERF ? m_flush : 32'd0);
  endtask

  task automatic step(input string tag, input logic [6:0] v, input bit use_tbl,
                      input logic [9:0] tbl_exp);
    logic [9:0] exp;
    @(negedge CLK);
    {ihit, dhit, mem_req_ex, load_use, branch_taken, jump, halt_mem} = v;
    #1;
    exp = use_tbl ? tbl_exp : model_out(v);
    check({tag, " outputs"}, {22'd0, dut_out()}, {22'd0, exp});
    check_cnts(tag);
    $display("%s in=%b out=%b exp=%b stall=%0d flush=%0d", tag, v, dut_out(), exp,
             stall_cnt, flush_cnt);
    model_update(v);
  endtask

  task automatic reset_mid(input string tag, input logic [6:0] v);
    @(negedge CLK);
    {ihit, dhit, mem_req_ex, load_use, branch_taken, jump, halt_mem} = v;
    #2;
    nRST = 1'b0;
    #1;
    model_reset();
    check({tag, " outputs"}, {22'd0, dut_out()}, 32'd0);
    check_cnts(tag);
    $display("%s reset asserted in=%b out=%b", tag, v, dut_out());
    @(posedge CLK);
    #2;
    nRST = 1'b1;
  endtask

  initial begin
    tbl[0]  = {7'b1010000, 10'b0000000000};  // data miss x3
    tbl[1]  = {7'b1010000, 10'b0000000000};
    tbl[2]  = {7'b1010000, 10'b0000000000};
    tbl[3]  = {7'b1110000, 10'b1111100000};  // data hit releases pipe
    tbl[4]  = {7'b0110000, 10'b0000000000};  // data hit under fetch miss
    tbl[5]  = {7'b0110000, 10'b0000000010};  // mask now up
    tbl[6]  = {7'b1010000, 10'b1111100010};  // fetch returns, access not re-waited
    tbl[7]  = {7'b1000000, 10'b1111100000};  // mask cleared
    tbl[8]  = {7'b1001000, 10'b0011101000};  // load-use bubble
    tbl[9]  = {7'b1001000, 10'b1111100000};  // held load_use does not stall twice
    tbl[10] = {7'b1001110, 10'b1111111100};  // branch beats load_use and jump
    tbl[11] = {7'b1000010, 10'b1111110000};  // jump
    tbl[12] = {7'b0001000, 10'b0000000000};  // freeze before load-use
    tbl[13] = {7'b1001000, 10'b0011101000};
    tbl[14] = {7'b0001000, 10'b0000000000};  // freeze with lu_done set
    tbl[15] = {7'b1001000, 10'b1111100000};
    tbl[16] = {7'b0000001, 10'b0000100000};  // halt beats freeze
    tbl[17] = {7'b1100000, 10'b0000000001};
    tbl[18] = {7'b0000100, 10'b0000000001};

    #1 nRST = 1'b0;
    #1;
    model_reset();
    check("reset outputs", {22'd0, dut_out()}, 32'd0);
    check_cnts("reset");
    @(posedge CLK);
    #2 nRST = 1'b1;

    for (int i = 0; i < 19; i++) step($sformatf("vec%0d", i), tbl[i].in, 1'b1, tbl[i].out);
    step("post_halt", 7'b1110000, 1'b0, 10'd0);

    reset_mid("rst_from_halt", 7'b1000000);
    step("pre_rst0", 7'b0110000, 1'b0, 10'd0);
    step("pre_rst1", 7'b0110000, 1'b0, 10'd0);
    reset_mid("rst_in_freeze", 7'b0110000);
    step("after_rst", 7'b1000000, 1'b1, 10'b1111100000);

    for (int i = 0; i < 600; i++) begin
      logic [6:0] v;
      v[6] = ($urandom_range(3) != 0);
      v[5] = $urandom_range(1);
      v[4] = ($urandom_range(4) < 2);
      v[3] = ($urandom_range(9) < 3);
      v[2] = ($urandom_range(6) == 0);
      v[1] = ($urandom_range(6) == 0);
      v[0] = ($urandom_range(49) == 0);
      if (m_halted && $urandom_range(7) == 0) reset_mid($sformatf("rnd_rst%0d", i), v);
      else step($sformatf("rnd%0d", i), v, 1'b0, 10'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
